cdu_counter_bank: RTL

Parametrised multi-channel read-counter and AGC pulse generator for the coupling data unit. Holds one angle counter per gimbal channel, driven by the single-LSB up/down steps from each channel's error-angle logic. Converts the accumulated steps into rate-limited +/− count pulses to the AGC, sharing one pulse slot among all channels by round-robin arbitration. It replaces the fixed single-axis read counter/pulse path and runs inner, middle and outer (or more) axes from one instance.

---
 rtl/cdu_counter_bank.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cdu_counter_bank.sv
// Multi-channel CDU angle counters with a shared, round-robin, rate-limited AGC pulse slot.
// Define CDU_OVF_FLAG_EN to build the sticky per-channel backlog-overflow flags.
module cdu_counter_bank #(
  parameter int NCH       = 3,
  parameter int WIDTH     = 16,
  parameter int PEND_W    = 4,
  parameter int PULSE_DIV = 4
) (
  input  logic                 CLOCKH,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       CDUZ,
  input  logic [NCH-1:0]       UPLVL,
  input  logic [NCH-1:0]       DNLVL,
  output logic [NCH*WIDTH-1:0] ANGLE,
  output logic [NCH-1:0]       PCHP,
  output logic [NCH-1:0]       PCHM,
  output logic [NCH-1:0]       OVF
);
  localparam int TW = $clog2(PULSE_DIV);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [TW-1:0] TMAX = TW'(PULSE_DIV - 1);
  localparam logic signed [PEND_W+1:0] ONE_X  = (PEND_W+2)'(1);
  localparam logic signed [PEND_W+1:0] PMAX_X = (PEND_W+2)'(2**(PEND_W-1) - 1);
  localparam logic signed [PEND_W+1:0] NMAX_X = -PMAX_X;

  function automatic logic signed [PEND_W+1:0] net_step(input logic up, input logic dn);
    if (up && !dn) return ONE_X;
    if (dn && !up) return -ONE_X;
    return '0;
  endfunction

  function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [PEND_W+1:0] v);
    if (v > PMAX_X) return PMAX_X[PEND_W-1:0];
    if (v < NMAX_X) return NMAX_X[PEND_W-1:0];
    return v[PEND_W-1:0];
  endfunction

  function automatic logic over_lim(input logic signed [PEND_W+1:0] v);
    return (v > PMAX_X) || (v < NMAX_X);
  endfunction

  logic        [WIDTH-1:0]  angle_p1 [NCH];
  logic signed [PEND_W-1:0] pend_p1  [NCH];
  logic        [WIDTH-1:0]  angle_p0 [NCH];
  logic signed [PEND_W-1:0] pend_p0  [NCH];
  logic signed [PEND_W+1:0] sum_p0   [NCH];
  logic [TW-1:0]  timer_p1;
  logic [PW-1:0]  ptr_p1;
  logic           tick_p0;
  logic           win_vld_p0;
  logic [PW-1:0]  win_ch_p0;
  logic [NCH-1:0] pchp_p0, pchm_p0;
  logic [NCH-1:0] pchp_p1, pchm_p1;

  // Stage p0: slot arbitration over the registered backlogs
  assign tick_p0 = (timer_p1 == TMAX);

  always_comb begin
    int idx;
    logic [PW-1:0] idx_w;
    idx        = 0;
    idx_w      = '0;
    win_vld_p0 = 1'b0;
    win_ch_p0  = ptr_p1;
    pchp_p0    = '0;
    pchm_p0    = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx   = (int'(ptr_p1) + k) % NCH;
      idx_w = PW'(idx);
      if (tick_p0 && !win_vld_p0 && (pend_p1[idx_w] != '0) && !CDUZ[idx_w]) begin
        win_vld_p0     = 1'b1;
        win_ch_p0      = idx_w;
        pchp_p0[idx_w] = ~pend_p1[idx_w][PEND_W-1];
        pchm_p0[idx_w] = pend_p1[idx_w][PEND_W-1];
      end
    end
  end

  // A step and a grant in the same cycle combine before saturation is judged
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sum_p0[i] = (PEND_W+2)'(pend_p1[i]) + net_step(UPLVL[i], DNLVL[i])
                - (pchp_p0[i] ? ONE_X : (pchm_p0[i] ? -ONE_X : '0));
      if (CDUZ[i]) begin
        angle_p0[i] = '0;
        pend_p0[i]  = '0;
      end else begin
        angle_p0[i] = angle_p1[i] + WIDTH'(net_step(UPLVL[i], DNLVL[i]));
        pend_p0[i]  = sat_pend(sum_p0[i]);
      end
    end
  end

  // Stage p1: counter, backlog, timer, pointer and pulse registers
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        angle_p1[i] <= '0;
        pend_p1[i]  <= '0;
      end
      timer_p1 <= '0;
      ptr_p1   <= PW'(NCH - 1);
      pchp_p1  <= '0;
      pchm_p1  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        angle_p1[i] <= angle_p0[i];
        pend_p1[i]  <= pend_p0[i];
      end
      timer_p1 <= tick_p0 ? '0 : timer_p1 + TW'(1);
      ptr_p1   <= win_ch_p0;
      pchp_p1  <= pchp_p0;
      pchm_p1  <= pchm_p0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_angle
    assign ANGLE[g*WIDTH +: WIDTH] = angle_p1[g];
  end

  assign PCHP = pchp_p1;
  assign PCHM = pchm_p1;

`ifdef CDU_OVF_FLAG_EN
  logic [NCH-1:0] sat_p0;
  logic [NCH-1:0] ovf_p1;

  always_comb begin
    sat_p0 = '0;
    for (int i = 0; i < NCH; i++) sat_p0[i] = over_lim(sum_p0[i]);
  end

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p1 <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (CDUZ[i])        ovf_p1[i] <= 1'b0;
        else if (sat_p0[i]) ovf_p1[i] <= 1'b1;
      end
    end
  end

  assign OVF = ovf_p1;
`else
  assign OVF = '0;
`endif

endmodule
